accum_frame_4b: RTL and testbench

- Sequential stage wrapped around the team's 4-bit ripple adder.
- Accepts a stream of 4-bit operands framed by a last flag and accumulates them into an 8-bit running sum.
- Presents one result per frame through a valid/ready handshake.
- The adder datapath is two chained 4-bit ripple adders; this block supplies their operands and registers their results every accepted beat.

---
 rtl/accum_frame_4b_pkg.sv | 14 +
 rtl/accum_frame_4b_adder.sv | 23 ++
 rtl/accum_frame_4b.sv | 115 +++++++++++
 tb/tb_accum_frame_4b.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/accum_frame_4b_pkg.sv
// Shared types and constants for the framed 4-bit accumulator.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam int ACC_W = 8;
    localparam int NIB_W = 4;
    localparam logic [ACC_W-1:0] SAT_VAL = 8'hFF;

endpackage

// File: rtl/accum_frame_4b_adder.sv
// Nibble-wide ripple-carry adder; two instances form the 8-bit accumulate path.
module accum_frame_4b_adder
    import accum_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/accum_frame_4b.sv
// Framed operand accumulator with valid/ready result handshake.
// Optional: define ACCUM_SATURATE_EN to clamp the sum at 0xFF instead of wrapping.
module accum_frame_4b
    import accum_pkg::*;
#(
    parameter int MAX_OPS = 15,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic             out_ovf,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             err;
    logic [CNT_W-1:0] count;

    logic [NIB_W-1:0] lo_s, hi_s;
    logic             lo_cout, hi_cout;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat;

    accum_frame_4b_adder u_lo (
        .a    (acc[NIB_W-1:0]),
        .b    (in_data),
        .cin  (1'b0),
        .s    (lo_s),
        .cout (lo_cout)
    );

    accum_frame_4b_adder u_hi (
        .a    (acc[ACC_W-1:NIB_W]),
        .b    ({NIB_W{1'b0}}),
        .cin  (lo_cout),
        .s    (hi_s),
        .cout (hi_cout)
    );

`ifdef ACCUM_SATURATE_EN
    // Once the frame has overflowed the sum pins at the ceiling.
    assign acc_nxt = (hi_cout || ovf) ? SAT_VAL : {hi_s, lo_s};
`else
    assign acc_nxt = {hi_s, lo_s};
`endif

    assign cnt_inc = count + 1'b1;
    assign beat    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc   <= acc_nxt;
                        ovf   <= ovf | hi_cout;
                        count <= cnt_inc;
                        if (in_last || cnt_inc == MAX_CNT) begin
                            state     <= HOLD;
                            err       <= !in_last;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Result drains and the frame clears on the same edge.
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        err       <= 1'b0;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_err   = err;
    assign out_count = count;

endmodule

// File: tb/tb_accum_frame_4b.sv
// Randomized bench for accum_frame_4b against a frame-level arithmetic model.
module tb_accum_frame_4b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, out_ready;
    logic [3:0] in_data;
    logic       sel;  // 0: default DUT (MAX_OPS=15), 1: wide DUT (MAX_OPS=20)

    logic       a_in_ready, a_out_valid, a_ovf, a_err;
    logic [7:0] a_sum;
    logic [3:0] a_count;
    logic       b_in_ready, b_out_valid, b_ovf, b_err;
    logic [7:0] b_sum;
    logic [4:0] b_count;

    logic       o_in_ready, o_valid, o_ovf, o_err;
    logic [7:0] o_sum;
    logic [4:0] o_count;

    int checks = 0;
    int fails  = 0;
    int fd[0:31];

    always #5 clk = ~clk;

    accum_frame_4b dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready && !sel),
        .out_sum(a_sum), .out_ovf(a_ovf), .out_err(a_err), .out_count(a_count)
    );

    accum_frame_4b #(.MAX_OPS(20), .CNT_W(5)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready && sel),
        .out_sum(b_sum), .out_ovf(b_ovf), .out_err(b_err), .out_count(b_count)
    );

    assign o_in_ready = sel ? b_in_ready  : a_in_ready;
    assign o_valid    = sel ? b_out_valid : a_out_valid;
    assign o_sum      = sel ? b_sum       : a_sum;
    assign o_ovf      = sel ? b_ovf       : a_ovf;
    assign o_err      = sel ? b_err       : a_err;
    assign o_count    = sel ? b_count     : {1'b0, a_count};

    // Frame-level model: total of the operands, wrapped or clamped.
    function automatic logic [14:0] model(input int n, input bit last);
        int tot = 0;
        logic [7:0] s;
        bit ov;
        for (int i = 0; i < n; i++) tot += fd[i];
        ov = (tot > 255);
`ifdef ACCUM_SATURATE_EN
        s = ov ? 8'hFF : tot[7:0];
`else
        s = tot[7:0];
`endif
        return {s, ov, !last, 5'(n)};
    endfunction

    // Sends fd[0..n-1], checks the result, applies `hold` stall cycles, then drains.
    task automatic do_frame(input string name, input int n, input bit last, input int hold);
        logic [14:0] exp_r, got_r;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(fd[i]);
            in_last  = last && (i == n - 1);
            checks++;
            if ({o_in_ready, o_valid} !== 2'b10) begin
                fails++;
                $display("FAIL %s beat%0d ready/valid: got %b want 10", name, i, {o_in_ready, o_valid});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        exp_r = model(n, last);
        got_r = {o_sum, o_ovf, o_err, o_count};
        checks++;
        if (o_valid !== 1'b1 || o_in_ready !== 1'b0 || got_r !== exp_r) begin
            fails++;
            $display("FAIL %s result: valid=%b ready=%b sum=%h ovf=%b err=%b cnt=%0d want sum=%h ovf=%b err=%b cnt=%0d",
                     name, o_valid, o_in_ready, o_sum, o_ovf, o_err, o_count,
                     exp_r[14:7], exp_r[6], exp_r[5], exp_r[4:0]);
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 4'($urandom);
            in_last   = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({o_valid, o_in_ready, o_sum, o_ovf, o_err, o_count} !== {2'b10, exp_r}) begin
                fails++;
                $display("FAIL %s stall%0d: valid=%b ready=%b sum=%h cnt=%0d want sum=%h cnt=%0d",
                         name, h, o_valid, o_in_ready, o_sum, o_count, exp_r[14:7], exp_r[4:0]);
            end
        end
        // Handshake cycle with a beat offered: it must not be consumed.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'hF;
        in_last   = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if ({o_valid, o_in_ready, o_sum, o_ovf, o_err, o_count} !== {2'b01, 15'd0}) begin
            fails++;
            $display("FAIL %s drain: valid=%b ready=%b sum=%h ovf=%b err=%b cnt=%0d want 0/1/00/0/0/0",
                     name, o_valid, o_in_ready, o_sum, o_ovf, o_err, o_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({a_in_ready, a_out_valid, a_sum, a_ovf, a_err, a_count} !== {2'b10, 14'd0}) begin
            fails++;
            $display("FAIL reset: ready=%b valid=%b sum=%h ovf=%b err=%b cnt=%0d want 1/0/00/0/0/0",
                     a_in_ready, a_out_valid, a_sum, a_ovf, a_err, a_count);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        fd[0] = 3; fd[1] = 5; fd[2] = 7;
        do_frame("basic_3_5_7", 3, 1'b1, 0);
    endtask

    task automatic test_limit();
        for (int i = 0; i < 15; i++) fd[i] = 15;
        do_frame("max_last_0xF", 15, 1'b1, 0);
        for (int i = 0; i < 15; i++) fd[i] = 1;
        do_frame("force_close", 15, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        fd[0] = 9; fd[1] = 6;
        do_frame("backpressure", 2, 1'b1, 5);
        fd[0] = 2;
        do_frame("after_stall", 1, 1'b1, 0);
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        for (int i = 0; i < 16; i++) fd[i] = 15;
        fd[16] = 12; fd[17] = 5;  // 252 then +5 crosses 256
        do_frame("ovf_wrap", 18, 1'b1, 1);
        for (int i = 0; i < 20; i++) fd[i] = 14;
        do_frame("ovf_force_close", 20, 1'b0, 0);
        for (int f = 0; f < 4; f++) begin
            int n = $urandom_range(20, 1);
            bit l = (n < 20) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < n; i++) fd[i] = $urandom_range(15, 8);
            do_frame("wide_random", n, l, $urandom_range(2, 0));
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n = $urandom_range(15, 1);
            bit l = (n < 15) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < n; i++) fd[i] = $urandom_range(15, 0);
            do_frame("random", n, l, $urandom_range(3, 0));
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 4'd4; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_in_ready, a_out_valid, a_sum, a_ovf, a_err, a_count} !== {2'b10, 14'd0}) begin
            fails++;
            $display("FAIL mid_reset: ready=%b valid=%b sum=%h cnt=%0d want 1/0/00/0",
                     a_in_ready, a_out_valid, a_sum, a_count);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fd[0] = 2;
        do_frame("post_reset", 1, 1'b1, 0);
    endtask

    initial begin
        sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_limit();
        test_backpressure();
        test_overflow();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
